eq_band_mixer: RTL

Parametrised, time-multiplexed band-gain mixer and volume stage for the equalizer datapath. It accepts one frame per rising edge of `in_vld`: NUM_CH channels × NUM_BANDS filtered band samples. It scales each band by its pot gain, sums the bands, saturates, applies master volume and saturates again, all on a single shared multiplier. It sits between the band FIR bank and the output/DAC path, replacing per-band combinational scalers. It adds arbitrary channel/band counts, overrun detection and a gated amplifier-enable.

---
 rtl/eq_band_mixer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/eq_band_mixer.sv
// Time-multiplexed band-gain mixer + master volume on one shared multiplier.
// Optional warm-up gating of amp_on/smpl_out when EQ_MIXER_AMP_DLY_EN is defined.
module eq_band_mixer #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int WARMUP    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_vld,
  input  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]  band_in,
  input  logic [NUM_BANDS*12-1:0]             band_pot,
  input  logic [11:0]                         vol_pot,
  output logic [NUM_CH*DATA_W-1:0]            smpl_out,
  output logic                                out_vld,
  output logic                                busy,
  output logic                                overrun,
  output logic                                amp_on
);

  localparam int PROD_W = DATA_W + 13;
  localparam int ACC_W  = DATA_W + 13 + $clog2(NUM_BANDS) + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int B_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_VOL, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic                       vld_q;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [B_W-1:0]             b_q, b_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   res_q [NUM_CH];
  logic signed [DATA_W-1:0]   res_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   smpl_q, smpl_d;
  logic                       out_vld_q, out_vld_d;
  logic                       ovr_q, ovr_d;
  logic                       amp_q, amp_d;

  logic signed [DATA_W-1:0]   smp_q [NUM_CH][NUM_BANDS];
  logic [11:0]                pot_q [NUM_BANDS];
  logic [11:0]                vol_q;

  logic                       start;
  logic                       cap_en;
  logic signed [DATA_W-1:0]   mul_a;
  logic signed [12:0]         mul_g;
  logic signed [PROD_W-1:0]   a_ext, g_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [DATA_W-1:0]   mix, vol_res;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return x[DATA_W-1:0];
  endfunction

  assign start  = in_vld & ~vld_q;
  assign cap_en = start && (state_q == S_IDLE);

  // Single multiplier: band sample x band gain in MAC, mix x volume otherwise.
  always_comb begin
    mul_a = mix;
    mul_g = {1'b0, vol_q};
    if (state_q == S_MAC) begin
      mul_a = smp_q[ch_q][b_q];
      mul_g = {1'b0, pot_q[b_q]};
    end
  end

  assign a_ext    = {{13{mul_a[DATA_W-1]}}, mul_a};
  assign g_ext    = {{DATA_W{mul_g[12]}}, mul_g};
  assign prod     = a_ext * g_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign mix      = sat(acc_q >>> 11);
  assign vol_res  = sat(prod_ext >>> 11);

`ifdef EQ_MIXER_AMP_DLY_EN
  localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    b_d       = b_q;
    acc_d     = acc_q;
    res_d     = res_q;
    smpl_d    = smpl_q;
    out_vld_d = 1'b0;
    ovr_d     = ovr_q | (start & (state_q != S_IDLE));
`ifdef EQ_MIXER_AMP_DLY_EN
    cnt_d     = cnt_q;
    amp_d     = amp_q;
`else
    amp_d     = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          ch_d    = '0;
          b_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (b_q == B_W'(NUM_BANDS - 1)) state_d = S_VOL;
        else                            b_d = b_q + 1'b1;
      end
      S_VOL: begin
        res_d[ch_q] = vol_res;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = S_OUT;
        end else begin
          ch_d    = ch_q + 1'b1;
          b_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        for (int c = 0; c < NUM_CH; c++) smpl_d[c*DATA_W +: DATA_W] = res_q[c];
        out_vld_d = 1'b1;
        state_d   = S_IDLE;
`ifdef EQ_MIXER_AMP_DLY_EN
        // Warm-up frames are muted; amp enables on the last muted frame's pulse.
        if (int'(cnt_q) < WARMUP) begin
          smpl_d = '0;
          cnt_d  = cnt_q + 1'b1;
        end
        if (int'(cnt_q) + 1 >= WARMUP) amp_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vld_q     <= 1'b1;
      ch_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      smpl_q    <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      amp_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) res_q[c] <= '0;
`ifdef EQ_MIXER_AMP_DLY_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vld_q     <= in_vld;
      ch_q      <= ch_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      smpl_q    <= smpl_d;
      out_vld_q <= out_vld_d;
      ovr_q     <= ovr_d;
      amp_q     <= amp_d;
      res_q     <= res_d;
`ifdef EQ_MIXER_AMP_DLY_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Frame buffers decouple the in-flight frame from live input/pot changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q <= '0;
      for (int k = 0; k < NUM_BANDS; k++) pot_q[k] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_BANDS; k++) smp_q[c][k] <= '0;
    end else if (cap_en) begin
      vol_q <= vol_pot;
      for (int k = 0; k < NUM_BANDS; k++) pot_q[k] <= band_pot[k*12 +: 12];
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_BANDS; k++)
          smp_q[c][k] <= band_in[(c*NUM_BANDS+k)*DATA_W +: DATA_W];
    end
  end

  assign smpl_out = smpl_q;
  assign out_vld  = out_vld_q;
  assign busy     = (state_q != S_IDLE) | out_vld_q;
  assign overrun  = ovr_q;
  assign amp_on   = amp_q;

endmodule
